// File: rtl/sobolrng_pkg.sv
// Shared constants for the Sobol RNG block family.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// The counter and the downstream Sobol RNG blocks take their default
// counter width from here so the whole chain agrees on one width.
package sobolrng_pkg;

    // Default counter / sequence-index width shared by the RNG blocks.
    localparam int unsigned CNT_BITWIDTH = 8;

endpackage : sobolrng_pkg

// File: rtl/cnt_with_en.sv
// Free-running unsigned up-counter with count enable, wraps modulo 2^BITWIDTH.
// Latency: one cycle, an enabled rising edge is visible on oCnt right after that edge.
// Backpressure: none; iEn low simply holds the count, nothing is ever stalled or dropped.
//
// Ports:
//   iClk  - single clock, all state changes on the rising edge
//   iRstN - asynchronous active-low reset, forces oCnt to 0 at once;
//           its deassertion must already be synchronous to iClk
//   iEn   - count enable, sampled on rising iClk
//   oCnt  - current count, driven straight from the count register
module cnt_with_en
    import sobolrng_pkg::*;
#(
    parameter int BITWIDTH = CNT_BITWIDTH
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    output logic [BITWIDTH-1:0] oCnt
);

    logic [BITWIDTH-1:0] r_cnt;
    logic [BITWIDTH-1:0] w_cnt_inc;

    // Natural unsigned overflow of the adder gives the all-ones -> 0 wrap.
    assign w_cnt_inc = r_cnt + BITWIDTH'(1);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_cnt <= '0;
        end else if (iEn) begin
            r_cnt <= w_cnt_inc;
        end
    end

    assign oCnt = r_cnt;

`ifndef SYNTHESIS
    // Counter is 0 whenever reset is seen low at a clock edge.
    ap_reset_zero : assert property (@(posedge iClk) !iRstN |-> (r_cnt == '0));

    // Sampled r_cnt at an edge is the value produced by the previous edge,
    // so compare it against the previous sample plus the previous enable.
    ap_hold : assert property (@(posedge iClk) disable iff (!iRstN)
        ($past(iRstN) && !$past(iEn)) |-> (r_cnt == $past(r_cnt)));

    ap_incr : assert property (@(posedge iClk) disable iff (!iRstN)
        ($past(iRstN) && $past(iEn)) |-> (r_cnt == $past(r_cnt) + BITWIDTH'(1)));
`endif

endmodule : cnt_with_en

// File: tb/tb_cnt_with_en.sv
// Directed bench for cnt_with_en at widths 8, 4 and 1 sharing one stimulus.
// Inputs change and outputs are sampled 2 ns after each rising edge.
// Expected values are hand-computed constants.
module tb_cnt_with_en;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] cnt8;
    logic [3:0] cnt4;
    logic [0:0] cnt1;

    int n_chk  = 0;
    int n_pass = 0;

    cnt_with_en #(.BITWIDTH(8)) u_dut8 (.iClk(clk), .iRstN(rst_n), .iEn(en), .oCnt(cnt8));
    cnt_with_en #(.BITWIDTH(4)) u_dut4 (.iClk(clk), .iRstN(rst_n), .iEn(en), .oCnt(cnt4));
    cnt_with_en #(.BITWIDTH(1)) u_dut1 (.iClk(clk), .iRstN(rst_n), .iEn(en), .oCnt(cnt1));

    // Rising edges at 10, 20, 30 ... ns.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all(input string tag, input int e8, input int e4, input int e1);
        chk({tag, "_w8"}, 32'(cnt8), 32'(e8));
        chk({tag, "_w4"}, 32'(cnt4), 32'(e4));
        chk({tag, "_w1"}, 32'(cnt1), 32'(e1));
    endtask

    // Reset is asserted between edges and held across one edge before release.
    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        #1;
        chk_all("rst_async", 0, 0, 0);
        tick();
        chk_all("rst_held", 0, 0, 0);
        rst_n = 1'b1;
        en    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;

        // Reset then run: reset low 0..15 ns, edge at 10 ns inside reset.
        #12;
        chk_all("reset_state", 0, 0, 0);
        #3;
        rst_n = 1'b1;
        en    = 1'b1;
        tick();                           // edge at 20 ns
        chk_all("first_edge", 1, 1, 1);

        // Edge k leaves count k (mod width) while enabled.
        for (int k = 2; k <= 258; k++) begin
            tick();
            if (k == 2)   chk("w1_wrap", 32'(cnt1), 32'd0);
            if (k == 15)  chk("w4_allones", 32'(cnt4), 32'd15);
            if (k == 16)  chk("w4_wrap", 32'(cnt4), 32'd0);
            if (k == 17)  chk("w4_after_wrap", 32'(cnt4), 32'd1);
            if (k == 40)  chk_all("run_400ns", 40, 8, 0);
            if (k == 255) chk("w8_allones", 32'(cnt8), 32'd255);
            if (k == 256) chk_all("w8_wrap", 0, 0, 0);
            if (k == 257) chk("w8_after_wrap1", 32'(cnt8), 32'd1);
            if (k == 258) chk_all("w8_after_wrap2", 2, 2, 0);
        end

        // Enable gating: count to 5, hold for 3 edges, then 6.
        do_reset();
        en = 1'b1;
        repeat (5) tick();
        chk_all("gate_five", 5, 5, 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("gate_hold", 5, 5, 1);
        end
        en = 1'b1;
        tick();
        chk_all("gate_resume", 6, 6, 0);

        // Async reset mid-count at 17.
        repeat (11) tick();
        chk_all("mid_seventeen", 17, 1, 1);
        rst_n = 1'b0;
        #1;
        chk_all("mid_async_zero", 0, 0, 0);
        repeat (2) begin
            tick();
            chk_all("mid_held_low", 0, 0, 0);
        end
        rst_n = 1'b1;
        tick();
        chk_all("post_reset_first", 1, 1, 1);

        // Alternating enable, starting high, for 20 edges.
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) chk("alt_edge1", 32'(cnt8), 32'd1);
            if (i == 2) chk("alt_edge2", 32'(cnt8), 32'd1);
            if (i == 3) chk("alt_edge3", 32'(cnt8), 32'd2);
            en = ~en;
        end
        chk_all("alt_final", 10, 10, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_cnt_with_en
